// File: rtl/jstk_pkg.sv
// Shared definitions for the joystick SPI poller: FSM encoding, byte layout of the
// joystick reply, command prefix and direction flag positions.
package jstk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StGap,
    StDone
  } state_e;

  localparam int unsigned X_LO = 0;
  localparam int unsigned X_HI = 1;
  localparam int unsigned Y_LO = 2;
  localparam int unsigned Y_HI = 3;
  localparam int unsigned BTN  = 4;

  localparam logic [5:0] CMD_PREFIX = 6'b100000;

  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  function automatic logic [7:0] make_cmd(input logic [1:0] led);
    return {CMD_PREFIX, led};
  endfunction

endpackage

// File: rtl/jstk_spi_poller_if.sv
// SPI pin bundle between the poller (master) and the joystick (slave).
interface jstk_spi_poller_if;
  logic sclk;
  logic mosi;
  logic cs;
  logic miso;

  modport master (output sclk, output mosi, output cs, input miso);
  modport slave  (input sclk, input mosi, input cs, output miso);
endinterface

// File: rtl/spi_byte_shifter.sv
// One mode-0 SPI byte: CLK_DIV clk cycles per SCLK half-period, MSB first,
// MISO captured on the edge where SCLK rises.
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic            active_q;
  logic            sclk_q;
  logic            mosi_q;
  logic [DivW-1:0] div_q;
  logic [2:0]      bit_q;
  logic [7:0]      tx_q;
  logic [7:0]      rx_q;
  logic            phase_end;

  assign phase_end = active_q && (div_q == DivLast);
  // Last cycle of bit 7's high phase; rx_q already holds the whole byte.
  assign done      = phase_end && sclk_q && (bit_q == 3'd7);
  assign rx_byte   = rx_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else if (go) begin
      // A go coinciding with done chains straight into the next byte.
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= tx_byte[7];
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= {tx_byte[6:0], 1'b0};
    end else if (active_q) begin
      if (phase_end) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso};
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd7) begin
            active_q <= 1'b0;
            mosi_q   <= 1'b0;
          end else begin
            bit_q  <= bit_q + 3'd1;
            mosi_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/jstk_spi_poller.sv
// Periodic SPI poller for a two-axis joystick: frames the transaction with CS,
// decodes position/buttons and derives dead-zone direction flags.
module jstk_spi_poller
  import jstk_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 50,
  parameter int unsigned NUM_BYTES   = 5,
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned CENTER      = 512,
  parameter int unsigned THRESH      = 100,
  parameter int unsigned CS_SETUP    = 1500,
  parameter int unsigned BYTE_GAP    = 1000,
  parameter int unsigned POLL_PERIOD = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [1:0]        led_cmd,
  jstk_spi_poller_if.master spi,
  output logic [DATA_W-1:0] x_pos,
  output logic [DATA_W-1:0] y_pos,
  output logic [2:0]        buttons,
  output logic [3:0]        dir,
  output logic              move_detect,
  output logic              sample_valid,
  output logic              busy
);

  localparam int unsigned CntMax = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned ByteW  = $clog2(NUM_BYTES);
  localparam int unsigned PollW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [CntW-1:0]   SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0]   GapLast   = CntW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [ByteW-1:0]  LastByte  = ByteW'(NUM_BYTES - 1);
  localparam logic [PollW-1:0]  PollLast  = PollW'(POLL_PERIOD - 1);
  localparam logic [DATA_W:0]   ThrHi     = (DATA_W + 1)'(CENTER + THRESH);
  localparam logic [DATA_W:0]   ThrLo     = (DATA_W + 1)'(CENTER - THRESH);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ByteW-1:0]  byte_q, byte_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic [1:0]        led_q;
  logic [7:0]        rx_store_q [5];
  logic [7:0]        rx_view [5];

  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, x_new, y_new;
  logic [2:0]        btn_q, btn_d;
  logic [3:0]        dir_q, dir_d, dir_new;
  logic              move_q, move_d;

  logic              accept, fin, go;
  logic [7:0]        tx_byte;
  logic              sh_done, sh_sclk, sh_mosi;
  logic [7:0]        sh_rx;

  assign accept = (state_q == StIdle) && (start || (enable && (poll_q == PollLast)));
  assign fin    = (state_q == StShift) && sh_done && (byte_q == LastByte);

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .tx_byte (tx_byte),
    .miso    (spi.miso),
    .done    (sh_done),
    .rx_byte (sh_rx),
    .sclk    (sh_sclk),
    .mosi    (sh_mosi)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      byte_q  <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      poll_q  <= poll_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    poll_d  = poll_q;
    if (enable) begin
      poll_d = (poll_q == PollLast) ? '0 : poll_q + PollW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          cnt_d   = '0;
          byte_d  = '0;
          poll_d  = '0;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) state_d = StShift;
        else                    cnt_d   = cnt_q + CntW'(1);
      end
      StShift: begin
        if (sh_done) begin
          if (byte_q == LastByte) begin
            state_d = StDone;
          end else begin
            byte_d = byte_q + ByteW'(1);
            if (BYTE_GAP != 0) begin
              state_d = StGap;
              cnt_d   = '0;
            end
          end
        end
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StShift;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reply bytes as seen this cycle, including the byte finishing right now.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      rx_view[i] = (sh_done && (byte_q == ByteW'(i))) ? sh_rx : rx_store_q[i];
    end
  end

  assign x_new = DATA_W'({rx_view[X_HI][1:0], rx_view[X_LO]});
  assign y_new = DATA_W'({rx_view[Y_HI][1:0], rx_view[Y_LO]});

  always_comb begin
    dir_new            = '0;
    dir_new[DIR_RIGHT] = {1'b0, x_new} > ThrHi;
    dir_new[DIR_LEFT]  = {1'b0, x_new} < ThrLo;
    dir_new[DIR_UP]    = {1'b0, y_new} > ThrHi;
    dir_new[DIR_DOWN]  = {1'b0, y_new} < ThrLo;
  end

  // Output logic: shifter launch plus next values of the registered outputs.
  always_comb begin
    go      = ((state_q == StSetup) && (cnt_q == SetupLast)) ||
              ((state_q == StGap) && (cnt_q == GapLast)) ||
              ((state_q == StShift) && sh_done && (byte_q != LastByte) && (BYTE_GAP == 0));
    // Byte 0 is only ever launched from setup; every later byte is zero.
    tx_byte = (state_q == StSetup) ? make_cmd(led_q) : 8'h00;
    cs_d    = cs_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    dir_d   = dir_q;
    move_d  = move_q;
    if (accept) begin
      cs_d   = 1'b0;
      busy_d = 1'b1;
    end
    if (fin) begin
      cs_d    = 1'b1;
      busy_d  = 1'b0;
      valid_d = 1'b1;
      x_d     = x_new;
      y_d     = y_new;
      btn_d   = rx_view[BTN][2:0];
      dir_d   = dir_new;
      move_d  = |dir_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      x_q     <= DATA_W'(CENTER);
      y_q     <= DATA_W'(CENTER);
      btn_q   <= '0;
      dir_q   <= '0;
      move_q  <= 1'b0;
      led_q   <= '0;
      for (int i = 0; i < 5; i++) rx_store_q[i] <= '0;
    end else begin
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      if (accept) led_q <= led_cmd;
      for (int i = 0; i < 5; i++) rx_store_q[i] <= rx_view[i];
    end
  end

  assign spi.cs       = cs_q;
  assign spi.sclk     = sh_sclk;
  assign spi.mosi     = sh_mosi;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign buttons      = btn_q;
  assign dir          = dir_q;
  assign move_detect  = move_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_jstk_spi_poller.sv
// Bench for jstk_spi_poller: behavioural joystick slave, vector table, random
// transactions against an arithmetic model, polling and reset sequences.
module tb_jstk_spi_poller;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned NUM_BYTES   = 5;
  localparam int unsigned DATA_W      = 10;
  localparam int unsigned CENTER      = 512;
  localparam int unsigned THRESH      = 100;
  localparam int unsigned CS_SETUP    = 4;
  localparam int unsigned BYTE_GAP    = 3;
  localparam int unsigned POLL_PERIOD = 400;
  localparam int CS_LOW_LEN = CS_SETUP + NUM_BYTES * 16 * CLK_DIV + (NUM_BYTES - 1) * BYTE_GAP;
  localparam int NBITS      = NUM_BYTES * 8;

  logic              clk = 1'b0;
  logic              rst, enable, start;
  logic [1:0]        led_cmd;
  logic [DATA_W-1:0] x_pos, y_pos;
  logic [2:0]        buttons;
  logic [3:0]        dir;
  logic              move_detect, sample_valid, busy;

  jstk_spi_poller_if spi_if ();

  jstk_spi_poller #(
    .CLK_DIV     (CLK_DIV),
    .NUM_BYTES   (NUM_BYTES),
    .DATA_W      (DATA_W),
    .CENTER      (CENTER),
    .THRESH      (THRESH),
    .CS_SETUP    (CS_SETUP),
    .BYTE_GAP    (BYTE_GAP),
    .POLL_PERIOD (POLL_PERIOD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .start        (start),
    .led_cmd      (led_cmd),
    .spi          (spi_if.master),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .buttons      (buttons),
    .dir          (dir),
    .move_detect  (move_detect),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model and bus monitor.
  logic [7:0] slave_bytes [NUM_BYTES];
  logic [7:0] mosi_bytes  [NUM_BYTES];
  int cyc, low_len, last_len, rises, first_rise, valid_cnt, fall_cnt, last_fall_cyc;
  int mode_viol, idle_viol;
  logic prev_cs, prev_sclk, prev_mosi;

  initial begin
    cyc = 0; low_len = 0; last_len = 0; rises = 0; first_rise = 0; valid_cnt = 0;
    fall_cnt = 0; last_fall_cyc = 0; mode_viol = 0; idle_viol = 0;
    prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
    spi_if.miso = 1'b0;
    for (int i = 0; i < NUM_BYTES; i++) mosi_bytes[i] = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_cs && !spi_if.cs) begin
        low_len = 0; rises = 0; first_rise = 0; fall_cnt++; last_fall_cyc = cyc;
        spi_if.miso = slave_bytes[0][7];
      end
      if (!spi_if.cs) low_len++;
      if (!prev_sclk && spi_if.sclk) begin
        if (rises == 0) first_rise = low_len;
        if (rises < NBITS) mosi_bytes[rises / 8][7 - rises % 8] = spi_if.mosi;
        rises++;
        // MISO is garbage while SCLK is high: only a rising-edge sample is valid.
        spi_if.miso = ~spi_if.miso;
      end
      if (prev_sclk && !spi_if.sclk && rises < NBITS)
        spi_if.miso = slave_bytes[rises / 8][7 - rises % 8];
      if (spi_if.sclk && (spi_if.mosi !== prev_mosi)) mode_viol++;
      if (spi_if.cs && spi_if.sclk) idle_viol++;
      if (!prev_cs && spi_if.cs) last_len = low_len;
      if (sample_valid) valid_cnt++;
      prev_cs = spi_if.cs; prev_sclk = spi_if.sclk; prev_mosi = spi_if.mosi;
    end
  end

  // Reference decode straight from the reply layout, in plain arithmetic.
  task automatic model(input logic [39:0] b, output int x, output int y, output int btn,
                       output logic [3:0] d);
    x   = (int'(b[31:24]) % 4) * 256 + int'(b[39:32]);
    y   = (int'(b[15:8]) % 4) * 256 + int'(b[23:16]);
    btn = int'(b[7:0]) % 8;
    d   = {y > int'(CENTER + THRESH), y < int'(CENTER - THRESH),
           x < int'(CENTER - THRESH), x > int'(CENTER + THRESH)};
  endtask

  task automatic load_slave(input logic [39:0] b);
    for (int i = 0; i < NUM_BYTES; i++) slave_bytes[i] = b[39 - 8 * i -: 8];
  endtask

  task automatic run_txn(input string tag, input logic [39:0] b, input logic [1:0] led,
                         input int ex, input int ey, input int ebtn, input logic [3:0] edir);
    int v0;
    bit seen;
    load_slave(b);
    led_cmd = led;
    v0 = valid_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; led_cmd = ~led;
    @(negedge clk);
    check({tag, " cs_low_after_accept"}, 64'(spi_if.cs), 64'(0));
    check({tag, " busy_after_accept"}, 64'(busy), 64'(1));
    seen = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (sample_valid) begin seen = 1'b1; break; end
    end
    check({tag, " sample_valid_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      check({tag, " cs_high_at_valid"}, 64'(spi_if.cs), 64'(1));
      check({tag, " busy_low_at_valid"}, 64'(busy), 64'(0));
      check({tag, " x_pos"}, 64'(x_pos), 64'(ex));
      check({tag, " y_pos"}, 64'(y_pos), 64'(ey));
      check({tag, " buttons"}, 64'(buttons), 64'(ebtn));
      check({tag, " dir"}, 64'(dir), 64'(edir));
      check({tag, " move_detect"}, 64'(move_detect), 64'(|edir));
    end
    repeat (3) @(negedge clk);
    #1;
    check({tag, " valid_pulses"}, 64'(valid_cnt - v0), 64'(1));
    check({tag, " cs_low_len"}, 64'(last_len), 64'(CS_LOW_LEN));
    check({tag, " first_rise"}, 64'(first_rise), 64'(CS_SETUP + CLK_DIV + 1));
    check({tag, " sclk_rises"}, 64'(rises), 64'(NBITS));
    check({tag, " mosi_bytes"},
          {24'h0, mosi_bytes[0], mosi_bytes[1], mosi_bytes[2], mosi_bytes[3], mosi_bytes[4]},
          {24'h0, 6'b100000, led, 32'h0});
  endtask

  typedef struct {
    logic [39:0] bytes;
    logic [1:0]  led;
    int          x;
    int          y;
    int          btn;
    logic [3:0]  dir;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int   rx, ry, rb, n0, v0, f1, f2;
    bit   seen;
    logic [39:0] rbytes;
    logic [3:0]  rd;

    tbl[0] = '{40'h58_02_00_02_05, 2'b00, 600, 512, 5, 4'b0000};
    tbl[1] = '{40'h65_02_9B_01_02, 2'b11, 613, 411, 2, 4'b0101};
    tbl[2] = '{40'h64_02_9C_01_00, 2'b01, 612, 412, 0, 4'b0000};
    tbl[3] = '{40'h9B_01_65_02_07, 2'b10, 411, 613, 7, 4'b1010};
    tbl[4] = '{40'h00_FD_FF_03_F8, 2'b00, 256, 1023, 0, 4'b1010};
    tbl[5] = '{40'h63_02_9D_01_06, 2'b11, 611, 413, 6, 4'b0000};

    rst = 1'b1; enable = 1'b0; start = 1'b0; led_cmd = 2'b00;
    load_slave(40'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cs", 64'(spi_if.cs), 64'(1));
    check("rst sclk", 64'(spi_if.sclk), 64'(0));
    check("rst mosi", 64'(spi_if.mosi), 64'(0));
    check("rst x_pos", 64'(x_pos), 64'(CENTER));
    check("rst y_pos", 64'(y_pos), 64'(CENTER));
    check("rst buttons_dir_move", {buttons, dir, move_detect}, 64'(0));
    check("rst valid_busy", {sample_valid, busy}, 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].bytes, tbl[i].led, tbl[i].x, tbl[i].y,
              tbl[i].btn, tbl[i].dir);

    for (int i = 0; i < 12; i++) begin
      rbytes = {$urandom(), 8'($urandom())};
      model(rbytes, rx, ry, rb, rd);
      run_txn($sformatf("rnd%0d", i), rbytes, 2'($urandom()), rx, ry, rb, rd);
    end

    // Auto-polling, ignored mid-transaction start, enable dropped mid-transaction.
    load_slave(tbl[1].bytes);
    n0 = fall_cnt; v0 = valid_cnt;
    @(posedge clk); #1 enable = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      if (fall_cnt > n0) begin seen = 1'b1; break; end
    end
    check("poll first_accept", 64'(seen), 64'(1));
    f1 = last_fall_cyc;
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      if (fall_cnt > n0 + 1) begin seen = 1'b1; break; end
    end
    check("poll second_accept", 64'(seen), 64'(1));
    f2 = last_fall_cyc;
    check("poll period", 64'(f2 - f1), 64'(POLL_PERIOD));
    check("poll valid_between", 64'(valid_cnt - v0), 64'(1));
    repeat (20) @(posedge clk);
    #1 enable = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      if (valid_cnt > v0 + 1) begin seen = 1'b1; break; end
    end
    check("poll disable completes", 64'(seen), 64'(1));
    repeat (3) @(negedge clk);
    #1;
    check("poll disable cs_low_len", 64'(last_len), 64'(CS_LOW_LEN));
    check("poll x_pos", 64'(x_pos), 64'(613));
    repeat (900) @(negedge clk);
    #1;
    check("poll stopped", 64'(fall_cnt), 64'(n0 + 2));

    // Reset in the middle of byte 2, then a clean transaction.
    n0 = fall_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      if (fall_cnt > n0 && rises >= 19) begin seen = 1'b1; break; end
    end
    check("rst_mid reached_byte2", 64'(seen), 64'(1));
    check("rst_mid cs_low_before", 64'(spi_if.cs), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid cs", 64'(spi_if.cs), 64'(1));
    check("rst_mid sclk", 64'(spi_if.sclk), 64'(0));
    check("rst_mid x_pos", 64'(x_pos), 64'(CENTER));
    check("rst_mid busy", 64'(busy), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_txn("after_rst", tbl[0].bytes, 2'b10, tbl[0].x, tbl[0].y, tbl[0].btn, tbl[0].dir);

    check("mosi_stable_while_sclk_high", 64'(mode_viol), 64'(0));
    check("sclk_low_while_cs_high", 64'(idle_viol), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
